// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-requester arbiter for a dual-port RAM with
// independent round-robin write and read arbitration and tagged read return.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  req0_rvalid,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  req1_rvalid,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  wr_enb,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_enb,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data
);

    logic                  run_q, run_d;
    logic                  wr_last_q, wr_last_d;
    logic                  rd_last_q, rd_last_d;
    logic                  wr_enb_q, wr_enb_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  rd_enb_q, rd_enb_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [RD_LATENCY:0]   tag_vld_q, tag_vld_d;
    logic [RD_LATENCY:0]   tag_id_q, tag_id_d;

    logic                  wr_cand0, wr_cand1, rd_cand0, rd_cand1;
    logic                  wr_pick1, rd_pick1, wr_gnt, rd_gnt, raw_hit;
    logic [ADDR_WIDTH-1:0] wr_sel_addr, rd_sel_addr;
    logic [DATA_WIDTH-1:0] wr_sel_data;

    always_comb begin
        wr_cand0    = req0_valid & req0_we;
        wr_cand1    = req1_valid & req1_we;
        rd_cand0    = req0_valid & ~req0_we;
        rd_cand1    = req1_valid & ~req1_we;
        // Under contention the requester that was not served last wins.
        wr_pick1    = wr_cand1 & (~wr_cand0 | ~wr_last_q);
        rd_pick1    = rd_cand1 & (~rd_cand0 | ~rd_last_q);
        wr_sel_addr = wr_pick1 ? req1_addr : req0_addr;
        wr_sel_data = wr_pick1 ? req1_wdata : req0_wdata;
        rd_sel_addr = rd_pick1 ? req1_addr : req0_addr;
        // run_q keeps every grant off until the first edge after reset release.
        wr_gnt      = run_q & (wr_cand0 | wr_cand1);
        raw_hit     = wr_gnt & (rd_sel_addr == wr_sel_addr);
        rd_gnt      = run_q & (rd_cand0 | rd_cand1) & ~raw_hit;

        req0_ready  = rst & ((wr_gnt & ~wr_pick1) | (rd_gnt & ~rd_pick1));
        req1_ready  = rst & ((wr_gnt & wr_pick1) | (rd_gnt & rd_pick1));

        run_d       = 1'b1;
        wr_last_d   = wr_gnt ? wr_pick1 : wr_last_q;
        rd_last_d   = rd_gnt ? rd_pick1 : rd_last_q;
        wr_enb_d    = wr_gnt;
        wr_addr_d   = wr_gnt ? wr_sel_addr : wr_addr_q;
        wr_data_d   = wr_gnt ? wr_sel_data : wr_data_q;
        rd_enb_d    = rd_gnt;
        rd_addr_d   = rd_gnt ? rd_sel_addr : rd_addr_q;
        tag_vld_d   = {tag_vld_q[RD_LATENCY-1:0], rd_gnt};
        tag_id_d    = {tag_id_q[RD_LATENCY-1:0], rd_pick1};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q     <= 1'b0;
            wr_last_q <= 1'b1;
            rd_last_q <= 1'b1;
            wr_enb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_enb_q  <= 1'b0;
            rd_addr_q <= '0;
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            run_q     <= run_d;
            wr_last_q <= wr_last_d;
            rd_last_q <= rd_last_d;
            wr_enb_q  <= wr_enb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_enb_q  <= rd_enb_d;
            rd_addr_q <= rd_addr_d;
            tag_vld_q <= tag_vld_d;
            tag_id_q  <= tag_id_d;
        end
    end

    assign wr_enb      = wr_enb_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign rd_enb      = rd_enb_q;
    assign rd_addr     = rd_addr_q;
    assign req0_rvalid = tag_vld_q[RD_LATENCY] & ~tag_id_q[RD_LATENCY];
    assign req1_rvalid = tag_vld_q[RD_LATENCY] & tag_id_q[RD_LATENCY];
    assign req0_rdata  = rd_data;
    assign req1_rdata  = rd_data;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - vector table plus read-return scoreboard for
// ram_port_arbiter with a behavioural one-cycle RAM.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_we, req1_valid, req1_we;
    logic [15:0] req0_addr, req1_addr;
    logic [7:0]  req0_wdata, req1_wdata;
    logic        req0_ready, req1_ready, req0_rvalid, req1_rvalid;
    logic [7:0]  req0_rdata, req1_rdata;
    logic        wr_enb, rd_enb;
    logic [15:0] wr_addr, rd_addr;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] mem    [0:65535];
    logic [7:0] shadow [0:65535];

    typedef struct {
        logic        v0, we0;
        logic [15:0] a0;
        logic [7:0]  d0;
        logic        v1, we1;
        logic [15:0] a1;
        logic [7:0]  d1;
        logic        r0, r1, wen, ren;
    } vec_t;

    typedef struct {
        logic       id;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];

    ram_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .RD_LATENCY(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (wr_enb) mem[wr_addr] <= wr_data;
        if (rd_enb) rd_data <= mem[rd_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Scoreboard: handshakes push expected read returns, rvalid pops them.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (req0_valid && req0_ready) begin
                if (req0_we) shadow[req0_addr] = req0_wdata;
                else sb.push_back('{1'b0, shadow[req0_addr], cyc + 2});
            end
            if (req1_valid && req1_ready) begin
                if (req1_we) shadow[req1_addr] = req1_wdata;
                else sb.push_back('{1'b1, shadow[req1_addr], cyc + 2});
            end
        end
        if (req0_rvalid && req1_rvalid) fail_now("rvalid_both");
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            fail_now("rvalid_missing");
            void'(sb.pop_front());
        end
        if (req0_rvalid || req1_rvalid) begin
            if (sb.size() == 0) fail_now("rvalid_unexpected");
            else begin
                e = sb.pop_front();
                chk("rd_id", 32'(req1_rvalid), 32'(e.id));
                chk("rd_data", 32'(req0_rvalid ? req0_rdata : req1_rdata), 32'(e.data));
                chk("rd_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    function automatic vec_t mk(input logic v0, we0, input logic [15:0] a0, input logic [7:0] d0,
                                input logic v1, we1, input logic [15:0] a1, input logic [7:0] d1,
                                input logic r0, r1, wen, ren);
        vec_t v;
        v = '{v0, we0, a0, d0, v1, we1, a1, d1, r0, r1, wen, ren};
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        req0_valid = v.v0; req0_we = v.we0; req0_addr = v.a0; req0_wdata = v.d0;
        req1_valid = v.v1; req1_we = v.we1; req1_addr = v.a1; req1_wdata = v.d1;
        @(negedge clk);
        chk({tag, ".rdy0"}, 32'(req0_ready), 32'(v.r0));
        chk({tag, ".rdy1"}, 32'(req1_ready), 32'(v.r1));
        @(posedge clk);
        #1;
        chk({tag, ".wen"}, 32'(wr_enb), 32'(v.wen));
        chk({tag, ".ren"}, 32'(rd_enb), 32'(v.ren));
        if (v.wen) begin
            chk({tag, ".waddr"}, 32'(wr_addr), 32'((v.r0 && v.we0) ? v.a0 : v.a1));
            chk({tag, ".wdata"}, 32'(wr_data), 32'((v.r0 && v.we0) ? v.d0 : v.d1));
        end
        if (v.ren) chk({tag, ".raddr"}, 32'(rd_addr), 32'((v.r0 && !v.we0) ? v.a0 : v.a1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Contended writes: grants alternate 0,1,0,1 from reset.
        tbl.push_back(mk(1,1,16'h10,8'hA0, 1,1,16'h11,8'hB0, 1,0,1,0));
        tbl.push_back(mk(1,1,16'h10,8'hA1, 1,1,16'h11,8'hB0, 0,1,1,0));
        tbl.push_back(mk(1,1,16'h10,8'hA1, 1,1,16'h11,8'hB1, 1,0,1,0));
        tbl.push_back(mk(1,1,16'h10,8'hA2, 1,1,16'h11,8'hB1, 0,1,1,0));
        tbl.push_back(mk(1,1,16'h10,8'hA2, 0,0,16'h00,8'h00, 1,0,1,0));
        // Write then read back.
        tbl.push_back(mk(1,1,16'h05,8'hA5, 0,0,16'h00,8'h00, 1,0,1,0));
        tbl.push_back(mk(1,0,16'h05,8'h00, 0,0,16'h00,8'h00, 1,0,0,1));
        tbl.push_back(mk(0,0,16'h00,8'h00, 0,0,16'h00,8'h00, 0,0,0,0));
        // Concurrent read and write, then read contention.
        tbl.push_back(mk(1,0,16'h05,8'h00, 1,1,16'h04,8'h44, 1,1,1,1));
        tbl.push_back(mk(1,0,16'h05,8'h00, 1,0,16'h04,8'h00, 0,1,0,1));
        tbl.push_back(mk(1,0,16'h05,8'h00, 0,0,16'h00,8'h00, 1,0,0,1));
        tbl.push_back(mk(1,0,16'h10,8'h00, 1,0,16'h11,8'h00, 0,1,0,1));
        tbl.push_back(mk(1,0,16'h10,8'h00, 0,0,16'h00,8'h00, 1,0,0,1));
        tbl.push_back(mk(0,0,16'h00,8'h00, 0,0,16'h00,8'h00, 0,0,0,0));
        // RAW: read of the address being written waits one cycle.
        tbl.push_back(mk(0,0,16'h00,8'h00, 1,1,16'h07,8'h11, 0,1,1,0));
        tbl.push_back(mk(1,0,16'h07,8'h00, 1,1,16'h07,8'h22, 0,1,1,0));
        tbl.push_back(mk(1,0,16'h07,8'h00, 0,0,16'h00,8'h00, 1,0,0,1));
        tbl.push_back(mk(0,0,16'h00,8'h00, 0,0,16'h00,8'h00, 0,0,0,0));
        tbl.push_back(mk(0,0,16'h00,8'h00, 0,0,16'h00,8'h00, 0,0,0,0));

        rst = 1'b1;
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 16'h10; req0_wdata = 8'hA0;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 16'h11; req1_wdata = 8'hB0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.rdy0", 32'(req0_ready), 0);
        chk("rst.rdy1", 32'(req1_ready), 0);
        chk("rst.wen", 32'(wr_enb), 0);
        chk("rst.ren", 32'(rd_enb), 0);
        chk("rst.rv0", 32'(req0_rvalid), 0);
        chk("rst.rv1", 32'(req1_rvalid), 0);
        chk("rst.waddr", 32'(wr_addr), 0);
        chk("rst.wdata", 32'(wr_data), 0);
        chk("rst.raddr", 32'(rd_addr), 0);
        rst = 1'b1;
        apply(mk(1,1,16'h10,8'hA0, 1,1,16'h11,8'hB0, 0,0,0,0), "release");

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset while a read is in flight: it must never return.
        apply(mk(1,1,16'h06,8'h66, 0,0,16'h00,8'h00, 1,0,1,0), "mr_wr");
        apply(mk(1,0,16'h05,8'h00, 0,0,16'h00,8'h00, 1,0,0,1), "mr_rd");
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        sb.delete();
        #1;
        chk("mr.ren", 32'(rd_enb), 0);
        chk("mr.wen", 32'(wr_enb), 0);
        chk("mr.raddr", 32'(rd_addr), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        apply(mk(1,1,16'h20,8'hC0, 1,1,16'h21,8'hD0, 0,0,0,0), "rel2");
        apply(mk(1,1,16'h20,8'hC0, 1,1,16'h21,8'hD0, 1,0,1,0), "ptr_wr");
        apply(mk(0,0,16'h00,8'h00, 1,1,16'h21,8'hD0, 0,1,1,0), "wr1");
        apply(mk(1,0,16'h05,8'h00, 1,0,16'h06,8'h00, 1,0,0,1), "ptr_rd");
        apply(mk(0,0,16'h00,8'h00, 1,0,16'h06,8'h00, 0,1,0,1), "rd1");
        for (int i = 0; i < 4; i++) apply(mk(0,0,16'h00,8'h00, 0,0,16'h00,8'h00, 0,0,0,0), "drain");

        chk("sb_empty", 32'(sb.size()), 0);
        chk("mem10", 32'(mem[16'h10]), 32'h A2);
        chk("mem11", 32'(mem[16'h11]), 32'h B1);
        chk("mem07", 32'(mem[16'h07]), 32'h22);
        chk("mem20", 32'(mem[16'h20]), 32'h C0);
        chk("mem21", 32'(mem[16'h21]), 32'h D0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
